// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache main-memory arbiter.
// Holds the FSM state enum, owner encoding and line/address widths.
package mem_arb_pkg;

    localparam int LINE_W         = 128;
    localparam int LADDR_W        = 28;
    localparam int ACCEPT_TIMEOUT = 16;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == ICACHE) ? DCACHE : ICACHE;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-way alternating-priority grant between icache and dcache.
// In: pending bits, last_owner. Out: grant_valid, grant_owner.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   i_pending,
    input  logic   d_pending,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

    always_comb begin
        grant_valid = i_pending | d_pending;
        grant_owner = ICACHE;
        unique case (1'b1)
            // contention: whoever did not go last wins
            (i_pending & d_pending):
                grant_owner = other_owner(last_owner);
            (d_pending & ~i_pending):
                grant_owner = DCACHE;
            default:
                grant_owner = ICACHE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide main memory port between icache and dcache.
// Ports: icache/dcache client ports, mem_* port, sticky timeout_err.
module mem_port_arbiter #(
    parameter int LINE_W         = mem_arb_pkg::LINE_W,
    parameter int LADDR_W        = mem_arb_pkg::LADDR_W,
    parameter int ACCEPT_TIMEOUT = mem_arb_pkg::ACCEPT_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_read,
    input  logic [LADDR_W-1:0] i_address,
    output logic [LINE_W-1:0]  i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [LADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0]  d_writedata,
    output logic [LINE_W-1:0]  d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0]  mem_writedata,
    input  logic [LINE_W-1:0]  mem_readdata,
    input  logic               mem_busywait,
    output logic               timeout_err
);

    import mem_arb_pkg::*;

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(ACCEPT_TIMEOUT - 1);

    arb_state_e       state_q;
    arb_state_e       state_d;
    owner_e           owner_q;
    owner_e           last_q;
    logic [CNT_W-1:0] cnt_q;

    logic   i_pending;
    logic   d_pending;
    logic   grant_valid;
    owner_e grant_owner;
    logic   timeout_hit;
    logic   done_i;
    logic   done_d;

    assign i_pending = i_read;
    assign d_pending = d_read | d_write;

    mem_arb_grant u_grant (
        .i_pending   (i_pending),
        .d_pending   (d_pending),
        .last_owner  (last_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // last ISSUE cycle the memory may take to accept
    assign timeout_hit = (cnt_q == TO_LAST);

    assign done_i = (state_q == DONE) && (owner_q == ICACHE);
    assign done_d = (state_q == DONE) && (owner_q == DCACHE);

    // a non-owner stays stalled until its own DONE cycle
    assign i_busywait = i_pending && !done_i;
    assign d_busywait = d_pending && !done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_busywait) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (!mem_busywait) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q       <= ICACHE;
            last_q        <= ICACHE;
            cnt_q         <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        last_q  <= grant_owner;
                        cnt_q   <= '0;
                        if (grant_owner == DCACHE) begin
                            // write-back wins over a fill
                            mem_address   <= d_address;
                            mem_writedata <= d_writedata;
                            mem_write     <= d_write;
                            mem_read      <= !d_write;
                        end else begin
                            mem_address   <= i_address;
                            mem_writedata <= '0;
                            mem_write     <= 1'b0;
                            mem_read      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_busywait) begin
                        cnt_q <= '0;
                    end else if (timeout_hit) begin
                        cnt_q       <= '0;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (!mem_busywait) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (mem_read) begin
                            if (owner_q == DCACHE) begin
                                d_readdata <= mem_readdata;
                            end else begin
                                i_readdata <= mem_readdata;
                            end
                        end
                    end
                end
                DONE: begin
                    cnt_q <= '0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Transaction-level model plus directed scenarios with literal checks.
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic         clock;
    logic         reset;
    logic         i_read;
    logic [27:0]  i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read;
    logic         d_write;
    logic [27:0]  d_address;
    logic [127:0] d_writedata;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic         timeout_err;

    mem_port_arbiter #(
        .LINE_W         (128),
        .LADDR_W        (28),
        .ACCEPT_TIMEOUT (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .timeout_err   (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    int cmd_cycles = 0;
    int grants     = 0;
    int d_bw_cnt   = 0;
    logic [27:0]  last_addr;
    logic [127:0] last_wd;

    // memory environment
    int  lat       = 5;
    bit  never_acc = 0;
    int  mcnt      = 0;
    logic [127:0] store [logic [27:0]];

    function automatic logic [127:0] lookup(input logic [27:0] a);
        if (store.exists(a)) return store[a];
        return {4{4'h0, a}};
    endfunction

    initial begin
        mem_busywait = 1'b0;
        mem_readdata = '0;
        store[28'h0000010] = {16{8'hA5}};
        forever begin
            @(posedge clock);
            #1;
            if (!(mem_read || mem_write)) begin
                mem_busywait = 1'b0;
                mcnt = 0;
            end else if (never_acc) begin
                mem_busywait = 1'b0;
            end else if (mcnt < lat) begin
                mem_busywait = 1'b1;
                mcnt++;
            end else if (mem_busywait) begin
                mem_busywait = 1'b0;
                if (mem_read) mem_readdata = lookup(mem_address);
                else store[mem_address] = mem_writedata;
            end
        end
    end

    // transaction-level reference model
    logic         m_cmd, m_acc, m_fin, m_wr, m_own, m_last, m_terr;
    int           m_cnt;
    logic [27:0]  m_addr;
    logic [127:0] m_wd, m_ird, m_drd;
    logic ip, dp, pick_d;

    assign ip = i_read;
    assign dp = d_read | d_write;
    assign pick_d = dp && (!ip || !m_last);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cmd  <= 0; m_acc <= 0; m_fin <= 0; m_wr <= 0;
            m_own  <= 0; m_last <= 0; m_terr <= 0; m_cnt <= 0;
            m_addr <= '0; m_wd <= '0; m_ird <= '0; m_drd <= '0;
        end else if (m_fin) begin
            m_fin <= 0;
        end else if (m_cmd && !m_acc) begin
            if (mem_busywait) m_acc <= 1;
            else if (m_cnt + 1 == TO) begin
                m_cmd <= 0; m_fin <= 1; m_terr <= 1;
            end else m_cnt <= m_cnt + 1;
        end else if (m_cmd) begin
            if (!mem_busywait) begin
                m_cmd <= 0;
                m_fin <= 1;
                if (!m_wr) begin
                    if (m_own) m_drd <= mem_readdata;
                    else m_ird <= mem_readdata;
                end
            end
        end else if (ip || dp) begin
            m_own  <= pick_d;
            m_last <= pick_d;
            m_cmd  <= 1;
            m_acc  <= 0;
            m_cnt  <= 0;
            m_wr   <= pick_d && d_write;
            m_addr <= pick_d ? d_address : i_address;
            m_wd   <= pick_d ? d_writedata : '0;
        end
    end

    task automatic check_b(input string n, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b want %b", n, a, e);
        end
    endtask

    task automatic check_w(input string n, input logic [127:0] a,
                           input logic [127:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic check_i(input string n, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", n, a, e);
        end
    endtask

    task automatic compare_loop();
        logic cmd;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            cmd = mem_read | mem_write;
            if (d_read && d_write) begin
                tests++;
                fails++;
                $display("FAIL illegal_dreq: d_read and d_write both 1");
            end
            check_b("mem_read", mem_read, m_cmd && !m_wr);
            check_b("mem_write", mem_write, m_cmd && m_wr);
            if (cmd) check_w("mem_address", 128'(mem_address), 128'(m_addr));
            if (mem_write) check_w("mem_writedata", mem_writedata, m_wd);
            check_b("i_busywait", i_busywait, i_read && !(m_fin && !m_own));
            check_b("d_busywait", d_busywait,
                    (d_read || d_write) && !(m_fin && m_own));
            check_w("i_readdata", i_readdata, m_ird);
            check_w("d_readdata", d_readdata, m_drd);
            check_b("timeout_err", timeout_err, m_terr);
            if (cmd) begin
                cmd_cycles++;
                last_addr = mem_address;
                if (mem_write) last_wd = mem_writedata;
                if (!prev) grants++;
            end
            if (d_busywait) d_bw_cnt++;
            prev = cmd;
        end
    endtask

    // wait for the client's stall to drop, then release its request
    task automatic wait_client(input bit is_d, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            #1;
            if (is_d ? !d_busywait : !i_busywait) begin
                if (is_d) begin d_read = 0; d_write = 0; end
                else i_read = 0;
                return;
            end
            n++;
        end
        tests++;
        fails++;
        $display("FAIL wait_client: no completion within 200 cycles");
        i_read = 0; d_read = 0; d_write = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #3 reset = 0;
        @(negedge clock);
        #3 reset = 1;
    endtask

    int n, c0, g0, b0, di, ii;

    initial begin
        reset = 0; i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_address = '0; d_writedata = '0;
        fork
            compare_loop();
        join_none
        repeat (2) @(negedge clock);
        #1;
        check_b("rst_mem_read", mem_read, 1'b0);
        check_b("rst_mem_write", mem_write, 1'b0);
        check_w("rst_mem_address", 128'(mem_address), 128'h0);
        check_w("rst_mem_writedata", mem_writedata, 128'h0);
        check_w("rst_i_readdata", i_readdata, 128'h0);
        check_w("rst_d_readdata", d_readdata, 128'h0);
        check_b("rst_timeout_err", timeout_err, 1'b0);
        check_b("rst_i_busywait", i_busywait, 1'b0);
        #2 reset = 1;

        // single icache fill
        @(posedge clock); #2;
        c0 = cmd_cycles; b0 = d_bw_cnt;
        i_address = 28'h0000010; i_read = 1;
        wait_client(1'b0, n);
        check_i("t1_stall_cycles", n, 7);
        check_i("t1_cmd_cycles", cmd_cycles - c0, 6);
        check_w("t1_addr", 128'(last_addr), 128'h10);
        check_w("t1_rdata", i_readdata, {16{8'hA5}});
        check_i("t1_d_busy", d_bw_cnt - b0, 0);

        // contention straight after reset: dcache first
        do_reset();
        @(posedge clock); #2;
        i_address = 28'h0000030; d_address = 28'h0000040;
        i_read = 1; d_read = 1;
        di = 0; ii = 0;
        for (int k = 1; k <= 200 && (i_read || d_read); k++) begin
            @(negedge clock); #1;
            if (d_read && !d_busywait) begin d_read = 0; di = k; end
            if (i_read && !i_busywait) begin i_read = 0; ii = k; end
        end
        check_i("t2_d_done", di, 8);
        check_i("t2_i_done", ii, 16);
        check_w("t2_d_rdata", d_readdata, {4{32'h00000040}});
        check_w("t2_i_rdata", i_readdata, {4{32'h00000030}});

        // write-back then fill of the same line
        @(posedge clock); #2;
        d_address = 28'h1234567; d_writedata = {4{32'hDEADBEEF}};
        d_write = 1;
        wait_client(1'b1, n);
        check_i("t3_wb_stall", n, 7);
        check_w("t3_wb_addr", 128'(last_addr), 128'h1234567);
        check_w("t3_wb_data", last_wd, {4{32'hDEADBEEF}});
        check_w("t3_rdata_kept", d_readdata, {4{32'h00000040}});
        @(posedge clock); #2;
        d_writedata = '0; d_read = 1;
        wait_client(1'b1, n);
        check_w("t3_rdata", d_readdata, {4{32'hDEADBEEF}});

        // memory never accepts
        never_acc = 1;
        @(posedge clock); #2;
        c0 = cmd_cycles;
        d_address = 28'h0ABCDEF; d_read = 1;
        wait_client(1'b1, n);
        check_i("t4_stall", n, 17);
        check_i("t4_issue_cycles", cmd_cycles - c0, 16);
        check_b("t4_terr", timeout_err, 1'b1);
        check_w("t4_rdata_kept", d_readdata, {4{32'hDEADBEEF}});
        repeat (3) @(negedge clock);
        #1 check_b("t4_terr_sticky", timeout_err, 1'b1);
        never_acc = 0;

        // reset while waiting on memory
        @(posedge clock); #2;
        i_address = 28'h0000020; i_read = 1;
        repeat (3) @(negedge clock);
        #3 reset = 0;
        #1;
        check_b("t5_mem_read", mem_read, 1'b0);
        check_b("t5_terr", timeout_err, 1'b0);
        check_w("t5_i_rdata", i_readdata, 128'h0);
        i_read = 0;
        @(negedge clock);
        #3 reset = 1;
        @(posedge clock); #2;
        i_address = 28'h0000010; i_read = 1;
        wait_client(1'b0, n);
        check_i("t5_stall", n, 7);
        check_w("t5_rdata", i_readdata, {16{8'hA5}});

        // request withdrawn during ISSUE
        @(posedge clock); #2;
        c0 = cmd_cycles; g0 = grants;
        i_address = 28'h0000050; i_read = 1;
        @(negedge clock);
        @(negedge clock);
        #1 i_read = 0;
        repeat (12) @(negedge clock);
        #1;
        check_i("t6_grants", grants - g0, 1);
        check_i("t6_cmd_cycles", cmd_cycles - c0, 6);
        check_w("t6_rdata", i_readdata, {4{32'h00000050}});
        check_b("t6_i_busy", i_busywait, 1'b0);
        check_b("t6_idle", mem_read, 1'b0);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
